// File: rtl/inst_rom.sv
// Loadable instruction ROM: a CPU fetch port plus an IDLE/LOAD/RUN loader fed by a word stream.
// Define INST_ROM_ADDR_CHECK_EN to reject misaligned or out-of-range fetch addresses and flag them on addr_err.
module inst_rom #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rom_en,
  input  logic [31:0]           rom_addr,
  output logic [31:0]           rom_data,
  input  logic                  load_start,
  input  logic                  run_start,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  addr_err
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_W  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LAST_IDX = (DEPTH_LOG2 + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  last_accept;
  logic                  start_load;
  logic                  fetch_active;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;

  assign wr_idx       = word_count[DEPTH_LOG2-1:0];
  assign rd_idx       = rom_addr[DEPTH_LOG2+1:2];
  assign busy         = (state == LOAD);
  assign load_ready   = (state == LOAD) && (word_count < DEPTH_W);
  assign accept       = load_valid && load_ready;
  // The word that fills the last slot ends the load even without load_last.
  assign last_accept  = accept && (load_last || (word_count == LAST_IDX));
  assign fetch_active = (state == RUN) && rom_en;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    start_load = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next = LOAD;
          start_load = 1'b1;
        end else if (run_start) begin
          state_next = RUN;
        end
      end
      LOAD: begin
        if (last_accept) state_next = RUN;
      end
      RUN: begin
        if (load_start) begin
          state_next = LOAD;
          start_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_count <= '0;
      load_done  <= 1'b0;
    end else begin
      state     <= state_next;
      load_done <= last_accept;
      if (start_load) begin
        word_count <= '0;
      end else if (accept) begin
        word_count <= word_count + (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; reset only suppresses the write in flight.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem[wr_idx] <= load_data;
    end
  end

`ifdef INST_ROM_ADDR_CHECK_EN
  logic bad_addr;

  assign bad_addr = (rom_addr[1:0] != 2'b00) || (rom_addr[31:DEPTH_LOG2+2] != '0);
  assign rom_data = (fetch_active && !bad_addr) ? mem[rd_idx] : 32'h0;

  // Sticky until reset or a new load begins; clearing wins over a same-cycle error.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (start_load) begin
      addr_err <= 1'b0;
    end else if (fetch_active && bad_addr) begin
      addr_err <= 1'b1;
    end
  end
`else
  logic unused_addr_bits;

  // Byte offset and upper bits are don't-care: the fetch address wraps modulo DEPTH.
  assign unused_addr_bits = ^{rom_addr[31:DEPTH_LOG2+2], rom_addr[1:0]};
  assign rom_data         = fetch_active ? mem[rd_idx] : 32'h0;
  assign addr_err         = 1'b0;
`endif

endmodule
